// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Brief    : Stall/flush controller for a five-stage F/D/E/M/W pipeline.
//             Detects RAW hazards against the E and M stages, owns the
//             multiply/divide busy counter and counts stall cycles.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int CNT_W  = 4,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        RsD,
    input  logic [4:0]        RtD,
    input  logic [1:0]        TuseRsD,
    input  logic [1:0]        TuseRtD,
    input  logic              MDUUseD,
    input  logic              RegWriteE,
    input  logic [4:0]        WriteRegE,
    input  logic [1:0]        TnewE,
    input  logic              RegWriteM,
    input  logic [4:0]        WriteRegM,
    input  logic [1:0]        TnewM,
    input  logic              StartE,
    input  logic [CNT_W-1:0]  TimeE,
    input  logic              ExcReqM,
    output logic              EnPC,
    output logic              StallE,
    output logic              Req,
    output logic              MDUBusy,
    output logic [PERF_W-1:0] StallCnt
);

    // RUN: no MDU operation pending beyond this cycle.
    // MDU_WAIT: the registered counter still holds busy cycles.
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] c_TUSE_NONE = 2'd3;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [PERF_W-1:0] r_stall_cnt;

    logic w_req;
    logic w_start_eff;
    logic w_haz_rs_e;
    logic w_haz_rs_m;
    logic w_haz_rt_e;
    logic w_haz_rt_m;
    logic w_haz;
    logic w_mdu_busy;
    logic w_stall;

    // Hazard detection: a consumer in D stalls while its source is still in
    // flight and will not be ready by the time D needs it; $0 is never a source.
    always_comb begin
        w_haz_rs_e = (TuseRsD != c_TUSE_NONE) && RegWriteE && (WriteRegE != 5'd0)
                     && (WriteRegE == RsD) && (TuseRsD < TnewE);
        w_haz_rs_m = (TuseRsD != c_TUSE_NONE) && RegWriteM && (WriteRegM != 5'd0)
                     && (WriteRegM == RsD) && (TuseRsD < TnewM);
        w_haz_rt_e = (TuseRtD != c_TUSE_NONE) && RegWriteE && (WriteRegE != 5'd0)
                     && (WriteRegE == RtD) && (TuseRtD < TnewE);
        w_haz_rt_m = (TuseRtD != c_TUSE_NONE) && RegWriteM && (WriteRegM != 5'd0)
                     && (WriteRegM == RtD) && (TuseRtD < TnewM);
        w_haz      = w_haz_rs_e | w_haz_rs_m | w_haz_rt_e | w_haz_rt_m;
    end

    // Flush has priority: a start coincident with a flush belongs to a killed
    // instruction, and the flush forces all pipeline registers to advance.
    always_comb begin
        w_req       = ExcReqM;
        w_start_eff = StartE & ~w_req;
        w_mdu_busy  = w_start_eff | (r_state == MDU_WAIT);
        w_stall     = w_haz | (MDUUseD & w_mdu_busy);
    end

    // MDU busy counter and its state: a start reloads (even mid-operation),
    // otherwise count down to zero; a flush never cancels a running count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_state <= RUN;
        end else if (w_start_eff) begin
            r_cnt   <= TimeE;
            r_state <= (TimeE != '0) ? MDU_WAIT : RUN;
        end else if (r_cnt != '0) begin
            r_cnt   <= r_cnt - CNT_W'(1);
            r_state <= (r_cnt != CNT_W'(1)) ? MDU_WAIT : RUN;
        end
    end

    // Stall-cycle performance counter; cycles overridden by a flush do not count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !w_req) begin
            r_stall_cnt <= r_stall_cnt + PERF_W'(1);
        end
    end

    // Output mapping.
    always_comb begin
        Req      = w_req;
        EnPC     = w_req | ~w_stall;
        StallE   = ~w_req & w_stall;
        MDUBusy  = w_mdu_busy;
        StallCnt = r_stall_cnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Brief    : Self-checking bench for pipe_hazard_ctrl. Directed scenarios
//             followed by randomized traffic compared against a cycle-indexed
//             behavioural model (MDU busy tracked as an end-cycle number).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int CNT_W  = 4;
    localparam int PERF_W = 5;

    logic              clk;
    logic              rst;
    logic [4:0]        RsD, RtD;
    logic [1:0]        TuseRsD, TuseRtD;
    logic              MDUUseD;
    logic              RegWriteE;
    logic [4:0]        WriteRegE;
    logic [1:0]        TnewE;
    logic              RegWriteM;
    logic [4:0]        WriteRegM;
    logic [1:0]        TnewM;
    logic              StartE;
    logic [CNT_W-1:0]  TimeE;
    logic              ExcReqM;
    logic              EnPC, StallE, Req, MDUBusy;
    logic [PERF_W-1:0] StallCnt;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .PERF_W(PERF_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .RsD       (RsD),
        .RtD       (RtD),
        .TuseRsD   (TuseRsD),
        .TuseRtD   (TuseRtD),
        .MDUUseD   (MDUUseD),
        .RegWriteE (RegWriteE),
        .WriteRegE (WriteRegE),
        .TnewE     (TnewE),
        .RegWriteM (RegWriteM),
        .WriteRegM (WriteRegM),
        .TnewM     (TnewM),
        .StartE    (StartE),
        .TimeE     (TimeE),
        .ExcReqM   (ExcReqM),
        .EnPC      (EnPC),
        .StallE    (StallE),
        .Req       (Req),
        .MDUBusy   (MDUBusy),
        .StallCnt  (StallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: cycle index, last cycle the MDU stays busy, total stalls.
    int cyc        = 0;
    int mdu_end    = -1;
    int stall_tot  = 0;
    int obs_busy   = 0;
    bit m_stall_now;
    bit m_start;
    int m_time;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit haz(input logic [4:0] src, input logic [1:0] tuse,
                               input logic wr, input logic [4:0] dst, input logic [1:0] tnew);
        int need_in;
        int ready_in;
        need_in  = int'(tuse);
        ready_in = int'(tnew);
        if (tuse == 2'd3 || !wr || dst == 5'd0 || dst != src) return 1'b0;
        return ready_in > need_in;
    endfunction

    task automatic model_reset();
        mdu_end   = cyc - 1;
        stall_tot = 0;
    endtask

    // Compare all outputs against the model for the current input vector.
    task automatic eval_check();
        bit any_haz, req, start_eff, busy, stall;
        any_haz = haz(RsD, TuseRsD, RegWriteE, WriteRegE, TnewE) ||
                  haz(RsD, TuseRsD, RegWriteM, WriteRegM, TnewM) ||
                  haz(RtD, TuseRtD, RegWriteE, WriteRegE, TnewE) ||
                  haz(RtD, TuseRtD, RegWriteM, WriteRegM, TnewM);
        req       = ExcReqM;
        start_eff = StartE && !req;
        busy      = start_eff || (cyc <= mdu_end);
        stall     = any_haz || (MDUUseD && busy);
        check_val("req",      32'(Req),      32'(req));
        check_val("mdubusy",  32'(MDUBusy),  32'(busy));
        check_val("enpc",     32'(EnPC),     32'(req ? 1'b1 : !stall));
        check_val("stalle",   32'(StallE),   32'(req ? 1'b0 : stall));
        check_val("stallcnt", 32'(StallCnt), 32'(stall_tot % (1 << PERF_W)));
        if (MDUBusy) obs_busy++;
        m_stall_now = stall && !req;
        m_start     = start_eff;
        m_time      = int'(TimeE);
    endtask

    // One clock: inputs were set at posedge+1, check at posedge+5, advance.
    task automatic cycle();
        #4;
        eval_check();
        @(posedge clk);
        if (m_start) mdu_end = cyc + m_time;
        if (m_stall_now) stall_tot++;
        cyc++;
        #1;
    endtask

    task automatic set_idle();
        RsD = 5'd0; RtD = 5'd0; TuseRsD = 2'd3; TuseRtD = 2'd3;
        MDUUseD = 1'b0; RegWriteE = 1'b0; WriteRegE = 5'd0; TnewE = 2'd0;
        RegWriteM = 1'b0; WriteRegM = 5'd0; TnewM = 2'd0;
        StartE = 1'b0; TimeE = '0; ExcReqM = 1'b0;
    endtask

    // Pulse the asynchronous reset between clock edges (called at posedge+1).
    task automatic pulse_reset();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        // Reset state, with and without a flush request present.
        #2 eval_check();
        ExcReqM = 1'b1;
        #1 eval_check();
        ExcReqM = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Load-use hazard against E, then the same with a ready result.
        RsD = 5'd5; TuseRsD = 2'd0; RegWriteE = 1'b1; WriteRegE = 5'd5; TnewE = 2'd2;
        cycle();
        check_val("loaduse_cnt", 32'(StallCnt), 32'd1);
        TnewE = 2'd0;
        cycle();
        // $0 destination never stalls.
        RsD = 5'd0; WriteRegE = 5'd0; TnewE = 2'd2;
        cycle();
        // rt hazard against M.
        set_idle();
        RtD = 5'd9; TuseRtD = 2'd1; RegWriteM = 1'b1; WriteRegM = 5'd9; TnewM = 2'd2;
        cycle();

        // MDU: TimeE=5 with a dependent instruction held -> 6 stall cycles.
        set_idle();
        pulse_reset();
        obs_busy = 0;
        StartE = 1'b1; TimeE = 4'd5; MDUUseD = 1'b1;
        cycle();
        StartE = 1'b0;
        for (int i = 0; i < 7; i++) cycle();
        check_val("mdu5_busy_cycles", 32'(obs_busy), 32'd6);
        check_val("mdu5_stallcnt",    32'(StallCnt), 32'd6);

        // Start killed by a coincident flush.
        set_idle();
        StartE = 1'b1; TimeE = 4'd7; ExcReqM = 1'b1; MDUUseD = 1'b1;
        cycle();
        StartE = 1'b0; ExcReqM = 1'b0;
        #1 check_val("kill_busy", 32'(MDUBusy), 32'd0);
        cycle();

        // A running count survives a later flush: TimeE=4 -> 5 busy cycles.
        set_idle();
        obs_busy = 0;
        StartE = 1'b1; TimeE = 4'd4;
        cycle();
        StartE = 1'b0;
        cycle();
        ExcReqM = 1'b1;
        cycle();
        ExcReqM = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check_val("flush_survive_busy", 32'(obs_busy), 32'd5);

        // Asynchronous reset in the middle of an MDU operation.
        set_idle();
        StartE = 1'b1; TimeE = 4'd9; MDUUseD = 1'b1;
        cycle();
        StartE = 1'b0;
        cycle();
        cycle();
        #2 rst = 1'b1;
        #1 check_val("arst_busy", 32'(MDUBusy), 32'd0);
        check_val("arst_cnt", 32'(StallCnt), 32'd0);
        check_val("arst_enpc", 32'(EnPC), 32'd1);
        #1 rst = 1'b0;
        model_reset();
        cycle();

        // Stall counter wraps from all-ones to zero.
        set_idle();
        pulse_reset();
        RsD = 5'd3; TuseRsD = 2'd0; RegWriteE = 1'b1; WriteRegE = 5'd3; TnewE = 2'd1;
        for (int i = 0; i < (1 << PERF_W) - 1; i++) cycle();
        check_val("wrap_allones", 32'(StallCnt), 32'((1 << PERF_W) - 1));
        cycle();
        check_val("wrap_zero", 32'(StallCnt), 32'd0);

        // Randomized traffic against the model, with occasional async resets.
        for (int i = 0; i < 3000; i++) begin
            RsD       = 5'($urandom_range(0, 3));
            RtD       = 5'($urandom_range(0, 3));
            TuseRsD   = 2'($urandom_range(0, 3));
            TuseRtD   = 2'($urandom_range(0, 3));
            MDUUseD   = 1'($urandom_range(0, 1));
            RegWriteE = 1'($urandom_range(0, 1));
            WriteRegE = 5'($urandom_range(0, 3));
            TnewE     = 2'($urandom_range(0, 3));
            RegWriteM = 1'($urandom_range(0, 1));
            WriteRegM = 5'($urandom_range(0, 3));
            TnewM     = 2'($urandom_range(0, 3));
            StartE    = ($urandom_range(0, 7) == 0);
            TimeE     = CNT_W'($urandom_range(0, (1 << CNT_W) - 1));
            ExcReqM   = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 199) == 0) pulse_reset();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
